// File: rtl/spi_master_param.sv
// spi_master_param: full-duplex SPI master.
// - Word width, number of slave selects and SCLK divider are set by parameters.
// - Supports all four CPOL/CPHA modes.
// - The on-chip side uses a start/busy/done handshake.
// - SCLK is a registered divided clock.
// Optional macro SPI_LSB_FIRST_EN adds a lsb_first input that selects LSB-first
// shifting per transfer. Without it the block is always MSB-first.
module spi_master_param #(
    parameter int DATA_W  = 8,
    parameter int NUM_SS  = 1,
    parameter int CLK_DIV = 2
) (
    input  logic                                           clock_in,
    input  logic                                           reset,
    input  logic                                           start,
    input  logic                                           cpol,
    input  logic                                           cpha,
    input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] ss_sel,
    input  logic [DATA_W-1:0]                              datain,
`ifdef SPI_LSB_FIRST_EN
    input  logic                                           lsb_first,
`endif
    output logic [DATA_W-1:0]                              dataout,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           sclk,
    output logic                                           mosi,
    input  logic                                           miso,
    output logic [NUM_SS-1:0]                              ssn_out
);
    localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   dataout_q, dataout_d;
    logic                mosi_q, mosi_d;
    logic                sclk_q, sclk_d;
    logic [NUM_SS-1:0]   ssn_q, ssn_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                done_q, done_d;

    logic                tick;       // end of a half-period
    logic                lead_edge;  // the upcoming SCLK toggle is a leading edge
    logic                last_edge;  // the upcoming SCLK toggle is the final one
    logic                lsb_start;  // bit order requested with the pending start
    logic                lsb_act;    // bit order of the transfer in progress
    logic [NUM_SS-1:0]   ssn_sel;    // decoded slave select for the pending start

`ifdef SPI_LSB_FIRST_EN
    logic                lsb_q, lsb_d;
    assign lsb_start = lsb_first;
    assign lsb_act   = lsb_q;
`else
    assign lsb_start = 1'b0;
    assign lsb_act   = 1'b0;
`endif

    // One-hot active-low decode; an out-of-range index selects nothing.
    for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
        assign ssn_sel[gi] = (ss_sel != SS_W'(gi));
    end

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // LSB-first receive enters at the MSB so the first bit ends in bit 0.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic lsb,
                                                   input logic b);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    assign tick      = (div_cnt_q == DIV_LAST);
    assign lead_edge = ~edge_cnt_q[0];
    assign last_edge = (edge_cnt_q == EDGE_LAST);

    // Next-state and datapath decisions for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        dataout_d  = dataout_q;
        mosi_d     = mosi_q;
        sclk_d     = sclk_q;
        ssn_d      = ssn_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        done_d     = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        lsb_d      = lsb_q;
`endif

        if (state_q != IDLE) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                sclk_d = cpol_q;
                if (start) begin
                    state_d    = LEAD;
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    sclk_d     = cpol;
                    ssn_d      = ssn_sel;
                    rx_d       = '0;
`ifdef SPI_LSB_FIRST_EN
                    lsb_d      = lsb_start;
`endif
                    if (!cpha) begin
                        // First bit must already be on mosi before the first leading edge.
                        mosi_d = first_bit(datain, lsb_start);
                        tx_d   = shift_out(datain, lsb_start);
                    end else begin
                        tx_d   = datain;
                    end
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (tick) begin
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = last_edge ? '0 : edge_cnt_q + 1'b1;
                    if (lead_edge != cpha_q) begin
                        rx_d = shift_in(rx_q, lsb_act, miso);
                    end else if (cpha_q || !last_edge) begin
                        mosi_d = first_bit(tx_q, lsb_act);
                        tx_d   = shift_out(tx_q, lsb_act);
                    end
                    if (last_edge) begin
                        state_d = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    state_d   = IDLE;
                    ssn_d     = '1;
                    sclk_d    = cpol_q;
                    done_d    = 1'b1;
                    dataout_d = rx_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            dataout_q  <= '0;
            mosi_q     <= 1'b0;
            sclk_q     <= 1'b0;
            ssn_q      <= '1;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
            lsb_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            dataout_q  <= dataout_d;
            mosi_q     <= mosi_d;
            sclk_q     <= sclk_d;
            ssn_q      <= ssn_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            done_q     <= done_d;
`ifdef SPI_LSB_FIRST_EN
            lsb_q      <= lsb_d;
`endif
        end
    end

    assign dataout = dataout_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ssn_out = ssn_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param (DATA_W=8, NUM_SS=3, CLK_DIV=2).
// A behavioural SPI slave answers with a chosen word, or miso is looped back from mosi.
// Each accepted start pushes the expected result into a queue.
// A monitor pops the queue on every done pulse and checks the result.
module tb_spi_master_param;
    localparam int DW       = 8;
    localparam int NSS      = 3;
    localparam int CDIV     = 2;
    localparam int BUSY_CYC = (2 * DW + 2) * CDIV;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           cpol = 1'b0;
    logic           cpha = 1'b0;
    logic [1:0]     ss_sel = '0;
    logic [DW-1:0]  datain = '0;
    logic [DW-1:0]  dataout;
    logic           busy, done, sclk, mosi, miso;
    logic [NSS-1:0] ssn_out;
`ifdef SPI_LSB_FIRST_EN
    logic           lsb_first = 1'b0;
`endif

    always #5 clk = ~clk;

    spi_master_param #(.DATA_W(DW), .NUM_SS(NSS), .CLK_DIV(CDIV)) dut (
        .clock_in (clk),
        .reset    (reset),
        .start    (start),
        .cpol     (cpol),
        .cpha     (cpha),
        .ss_sel   (ss_sel),
        .datain   (datain),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .dataout  (dataout),
        .busy     (busy),
        .done     (done),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .ssn_out  (ssn_out)
    );

    typedef struct {
        logic [DW-1:0]  din;
        logic [DW-1:0]  dout;
        logic [NSS-1:0] ssn;
        logic           pol;
        int             id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   txn_id = 0;

    // Transfer context shared with the slave model.
    logic           cur_pol = 1'b0, cur_pha = 1'b0, cur_lsb = 1'b0;
    logic [DW-1:0]  cur_sw = '0;
    logic           loop_mode = 1'b0;
    logic           slave_miso = 1'b0;
    logic [DW-1:0]  slave_rx_word = '0;

    assign miso = loop_mode ? mosi : slave_miso;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural SPI slave.
    // - Selected while busy.
    // - Samples mosi on its mode's sample edge.
    // - Shifts out cur_sw on the other edge.
    initial begin
        logic          s_act, s_prev, s_lead;
        int            s_tx_n, s_rx_n;
        logic [DW-1:0] s_rx;
        s_act = 1'b0; s_prev = 1'b0; s_tx_n = 0; s_rx_n = 0; s_rx = '0;
        forever begin
            @(negedge clk);
            if (reset || !busy) begin
                s_act = 1'b0;
            end else if (!s_act) begin
                s_act = 1'b1; s_tx_n = 0; s_rx_n = 0; s_rx = '0;
                slave_rx_word = 'x;
                s_prev = sclk;
                if (!cur_pha) begin
                    slave_miso = cur_lsb ? cur_sw[0] : cur_sw[DW-1];
                    s_tx_n = 1;
                end
            end else begin
                if (sclk !== s_prev) begin
                    s_lead = (sclk !== cur_pol);
                    if ((s_lead && !cur_pha) || (!s_lead && cur_pha)) begin
                        if (s_rx_n < DW) begin
                            s_rx[cur_lsb ? s_rx_n : DW - 1 - s_rx_n] = mosi;
                            s_rx_n++;
                            if (s_rx_n == DW) slave_rx_word = s_rx;
                        end
                    end else if (s_tx_n < DW) begin
                        slave_miso = cur_lsb ? cur_sw[s_tx_n] : cur_sw[DW - 1 - s_tx_n];
                        s_tx_n++;
                    end
                end
                s_prev = sclk;
            end
        end
    end

    // Monitor: checks window properties and pops the scoreboard on every done.
    initial begin
        int   bcnt, tcnt;
        logic ss_bad, dout_bad, prev_busy, prev_sclk, prev_done;
        logic [DW-1:0] prev_dout;
        exp_t e;
        bcnt = 0; tcnt = 0; ss_bad = 0; dout_bad = 0;
        prev_busy = 0; prev_sclk = 0; prev_done = 0; prev_dout = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bcnt = 0; tcnt = 0; ss_bad = 0; dout_bad = 0; prev_done = 0;
            end else begin
                if (busy) begin
                    bcnt++;
                    if (exp_q.size() == 0) ss_bad = 1;
                    else if (ssn_out !== exp_q[0].ssn) ss_bad = 1;
                    if (prev_busy && sclk !== prev_sclk) tcnt++;
                end else if (ssn_out !== '1) begin
                    ss_bad = 1;
                end
                if (!done && dataout !== prev_dout) dout_bad = 1;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dataout", dataout, e.dout);
                        chk("slave_rx", slave_rx_word, e.din);
                        chk("busy_len", bcnt, BUSY_CYC);
                        chk("sclk_toggles", tcnt, 2 * DW);
                        chk("ssn_window", ss_bad, 0);
                        chk("sclk_idle", sclk, e.pol);
                        chk("busy_in_done", busy, 0);
                        chk("done_single", prev_done, 0);
                        chk("dout_hold", dout_bad, 0);
                        $display("txn %0d: din=%h dout=%h exp=%h ssn_exp=%b busy=%0d",
                                 e.id, e.din, dataout, e.dout, e.ssn, bcnt);
                    end
                    bcnt = 0; tcnt = 0; ss_bad = 0; dout_bad = 0;
                end
            end
            prev_busy = busy; prev_sclk = sclk; prev_done = done; prev_dout = dataout;
        end
    end

    // Drive one start (DUT idle or in its done cycle), push the expectation, then scramble inputs.
    task automatic issue(input logic [DW-1:0] d, input logic pol, input logic pha,
                         input logic [1:0] sel, input logic loopback, input logic [DW-1:0] sw,
                         input logic lsb);
        exp_t e;
        cur_pol = pol; cur_pha = pha; cur_lsb = lsb; cur_sw = sw; loop_mode = loopback;
        datain = d; cpol = pol; cpha = pha; ss_sel = sel;
`ifdef SPI_LSB_FIRST_EN
        lsb_first = lsb;
`endif
        e.din  = d;
        e.dout = loopback ? d : sw;
        e.ssn  = (sel < NSS) ? ~(NSS'(1) << sel) : '1;
        e.pol  = pol;
        e.id   = txn_id;
        txn_id++;
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        datain = DW'($urandom); cpol = 1'($urandom); cpha = 1'($urandom); ss_sel = 2'($urandom);
`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'($urandom);
`endif
    endtask

    task automatic spurious_start(input int dly);
        repeat (dly) @(negedge clk);
        start = 1'b1;
        datain = DW'($urandom);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", done, 1);
    endtask

    initial begin
        int   seen;
        logic b2b, lsb;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ssn", ssn_out, 3'b111);
        chk("rst_dataout", dataout, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Mode 0 loopback.
        issue(8'hA5, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);
        // Mode 3, slave returns all ones.
        issue(8'h3C, 1'b1, 1'b1, 2'd2, 1'b0, 8'hFF, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);
        // Out-of-range select still completes.
        issue(8'h5A, 1'b0, 1'b1, 2'd3, 1'b0, 8'h96, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);
        // Start while busy is ignored; start in the done cycle runs back-to-back.
        issue(8'hC3, 1'b1, 1'b0, 2'd1, 1'b1, 8'h00, 1'b0);
        spurious_start(5);
        wait_done();
        issue(8'h69, 1'b0, 1'b1, 2'd0, 1'b0, 8'h2D, 1'b0);
        wait_done();
`ifdef SPI_LSB_FIRST_EN
        repeat (2) @(negedge clk);
        issue(8'h01, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b1);
        wait_done();
        repeat (2) @(negedge clk);
        issue(8'h8E, 1'b1, 1'b1, 2'd1, 1'b0, 8'h4B, 1'b1);
        wait_done();
`endif

        // Reset in the 10th busy cycle aborts without a done.
        repeat (2) @(negedge clk);
        issue(8'hE7, 1'b0, 1'b0, 2'd0, 1'b0, 8'h81, 1'b0);
        repeat (9) @(negedge clk);
        chk("busy_before_rst", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_ssn", ssn_out, 3'b111);
        chk("abort_sclk", sclk, 0);
        chk("abort_dataout", dataout, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("no_done_after_abort", seen, 0);

        // Randomised transfers with mixed modes, selects, spurious and back-to-back starts.
        b2b = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
            lsb = 1'b0;
`ifdef SPI_LSB_FIRST_EN
            lsb = 1'($urandom);
`endif
            issue(DW'($urandom), 1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom), DW'($urandom), lsb);
            if ($urandom_range(0, 2) == 0) spurious_start($urandom_range(1, 15));
            wait_done();
            b2b = 1'($urandom_range(0, 1));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised successor to the team's 8-bit SPI shifter. A full-duplex SPI master with configurable word width, programmable SCLK divider, all four CPOL/CPHA modes and multiple one-hot-decoded slave selects. It sits between an on-chip IP, which uses a start/busy/done handshake, and external SPI slaves. SCLK is a registered divided clock, never a gated clock_in.

Parameters:
DATA_W, 8, bits per transfer (2..32)
NUM_SS, 1, number of slave-select outputs (1..8)
CLK_DIV, 2, clock_in cycles per SCLK half-period (>=1)

Ports:
clock_in  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request a transfer; accepted only when busy=0
cpol  input  1  SCLK idle level; sampled when start is accepted
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge; sampled when start is accepted
ss_sel  input  max(1,$clog2(NUM_SS))  slave index; sampled when start is accepted
datain  input  DATA_W  transmit word; sampled when start is accepted
dataout  output  DATA_W  last received word; held until the next done
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at end of transfer
sclk  output  1  SPI clock
mosi  output  1  master out
miso  input  1  master in
ssn_out  output  NUM_SS  active-low slave selects

Behaviour:
- Single clock domain, clock_in. Reset is synchronous and active-high: on reset=1 at a posedge, state=IDLE and the divider counter, bit counter and shift register are cleared. Outputs take: busy=0, done=0, dataout=0, sclk=0, mosi=0, ssn_out=all ones.
- States: IDLE, LEAD, XFER, TRAIL.
- Each non-IDLE state advances on half-period ticks. A tick occurs when the divider counter reaches CLK_DIV-1, after which the counter wraps to 0.
- IDLE:
  - sclk = the registered idle level (cpol of the last accepted start; 0 after reset).
  - On start=1, the next cycle has: busy=1, state=LEAD, ssn_out[ss_sel]=0 (others 1), shift register loaded with datain, cpol/cpha latched.
  - ss_sel >= NUM_SS: the start is accepted but no ssn_out line is asserted.
- LEAD: one half-period of SS setup; sclk stays idle. If cpha=0, mosi = first data bit during LEAD.
- XFER: 2*DATA_W half-period ticks, each toggling sclk. Odd ticks are leading edges, even ticks are trailing edges.
  - cpha=0: sample miso on leading edges; shift out the next bit on trailing edges (no shift after the last one).
  - cpha=1: drive the next bit on leading edges (the first one drives bit 0 of the order); sample on trailing edges.
- TRAIL: one half-period of SS hold with sclk idle, then return to IDLE. In that IDLE cycle: busy=0, done=1 for exactly one cycle, ssn_out=all ones, dataout=received word.
- Timing: busy stays high for exactly (2*DATA_W+2)*CLK_DIV cycles.
- Bit order: MSB-first by default.
- Boundary cases:
  - start while busy=1: ignored, with no effect on the current transfer.
  - start in the done cycle: accepted; busy rises again the next cycle.
  - cpol/cpha/ss_sel/datain changing mid-transfer: no effect.
  - Reset mid-transfer: everything takes reset values at that edge and no done is issued.
  - CLK_DIV=1: SCLK = clock_in/2.
  - dataout is never updated except at done.

Optional Feature:
SPI_LSB_FIRST_EN
- Defined: adds input port lsb_first (1 bit, sampled at start). When it is 1, transmit and receive are LSB-first: the shift register shifts right, and received bits enter at the MSB and end in the correct bit positions.
- Undefined: the port is absent and the block is always MSB-first.

Test Plan:
- DATA_W=8, CLK_DIV=2, cpol=0, cpha=0, datain=8'hA5, miso looped from mosi -> 8 rising sclk edges; dataout=8'hA5; busy high 36 cycles; single done pulse.
- Mode 3 (cpol=1, cpha=1), datain=8'h3C, miso tied 1 -> sclk idles 1 before/after; mosi bit sequence 0,0,1,1,1,1,0,0 on trailing edges; dataout=8'hFF.
- NUM_SS=4, ss_sel=2 -> ssn_out=4'b1011 for the whole busy window and 4'b1111 otherwise; ss_sel=3 with NUM_SS=3 -> ssn_out stays all ones, transfer still completes.
- Second start during busy, plus a start asserted in the done cycle -> first ignored (one done for the ongoing transfer); second begins next cycle, back-to-back with zero idle gap.
- reset=1 at the 10th busy cycle -> next cycle busy=0, ssn_out all ones, sclk=0, dataout=0, no done pulse.
- SPI_LSB_FIRST_EN defined, lsb_first=1, datain=8'h01, loopback -> first mosi bit=1; dataout=8'h01.
